// File: rtl/peb_pkg.sv
// peb_pkg: definitions shared by the PEB bus fabric.
//   - Wishbone router state encoding
//   - Wishbone address slot-field layout (address bit 0 is the MSB)
//   - data returned for invalid or timed-out Wishbone accesses
//   - multi_hot(): true when more than one bit of a select vector is set
package peb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUSY = 2'd1,
        WB_ACK  = 2'd2
    } wb_state_e;

    localparam int SLOT_LSB = 3;   // first address bit of the slot index
    localparam int SLOT_W   = 4;   // width of the slot index
    localparam int REGION_W = 3;   // leading address bits that must be zero

    localparam logic [7:0] ERR_DATA = 8'hFF;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_hot(input logic [15:0] v);
        return |(v & (v - 16'd1));
    endfunction

endpackage

// File: rtl/peb_bus_wb_router.sv
// peb_bus_wb_router: forwards one Wishbone transaction at a time to a card slot.
//   clk, reset        system clock, synchronous active-high reset
//   status_clear      clears wb_timeout_flag (wins over a same-cycle timeout)
//   wb_adr            Wishbone address bits [0:6] (region + slot index)
//   wb_stb_i/wb_cyc_i Wishbone strobe / cycle
//   wb_dat_o/wb_ack_o registered read data / single-cycle ack
//   slot_wb_stb       one-hot registered strobe to the selected slot
//   slot_wb_dat/ack   per-slot read data and ack
//   wb_timeout_flag   sticky: a transaction hit WB_TIMEOUT
module peb_bus_wb_router
    import peb_pkg::*;
#(
    parameter int SLOTS      = 4,
    parameter int WB_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    status_clear,
    input  logic [0:SLOT_LSB+SLOT_W-1] wb_adr,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic [7:0]              wb_dat_o,
    output logic                    wb_ack_o,
    output logic [SLOTS-1:0]        slot_wb_stb,
    input  logic [8*SLOTS-1:0]      slot_wb_dat,
    input  logic [SLOTS-1:0]        slot_wb_ack,
    output logic                    wb_timeout_flag
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TW = (WB_TIMEOUT > 0) ? $clog2(WB_TIMEOUT + 1) : 1;
    localparam logic [4:0] SLOTS_V = 5'(SLOTS);

    wb_state_e       state;
    logic [SW-1:0]   slot_sel;
    logic [TW-1:0]   timer;

    logic [3:0]       adr_slot;
    logic             adr_valid;
    logic [SLOTS-1:0] adr_hot;
    logic             sel_ack;
    logic [7:0]       sel_dat;

    assign adr_slot  = wb_adr[SLOT_LSB +: SLOT_W];
    assign adr_valid = (wb_adr[0 +: REGION_W] == '0) && ({1'b0, adr_slot} < SLOTS_V);

    // Decode the incoming slot and mux the latched slot's ack/data; acks on
    // any other slot never reach the FSM.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        adr_hot = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (SW'(s) == slot_sel) begin
                sel_ack = slot_wb_ack[s];
                sel_dat = slot_wb_dat[8*s +: 8];
            end
            if (5'(s) == {1'b0, adr_slot}) adr_hot[s] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= WB_IDLE;
            slot_sel        <= '0;
            timer           <= '0;
            wb_dat_o        <= '0;
            wb_ack_o        <= 1'b0;
            slot_wb_stb     <= '0;
            wb_timeout_flag <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        if (!adr_valid) begin
                            wb_dat_o <= ERR_DATA;
                            wb_ack_o <= 1'b1;
                            state    <= WB_ACK;
                        end else begin
                            slot_sel    <= SW'(adr_slot);
                            timer       <= '0;
                            slot_wb_stb <= adr_hot;
                            state       <= WB_BUSY;
                        end
                    end
                end
                WB_BUSY: begin
                    if (sel_ack) begin
                        wb_dat_o    <= sel_dat;
                        wb_ack_o    <= 1'b1;
                        slot_wb_stb <= '0;
                        state       <= WB_ACK;
                    end else if (timer == TW'(WB_TIMEOUT)) begin
                        wb_dat_o        <= ERR_DATA;
                        wb_ack_o        <= 1'b1;
                        wb_timeout_flag <= 1'b1;
                        slot_wb_stb     <= '0;
                        state           <= WB_ACK;
                    end else if (!wb_cyc_i) begin
                        // master gave up: drop the strobe, no ack
                        slot_wb_stb <= '0;
                        state       <= WB_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WB_ACK:  state <= WB_IDLE;
                default: state <= WB_IDLE;
            endcase
            if (status_clear) wb_timeout_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/peb_bus.sv
// peb_bus: N-slot expansion-box bus fabric.
//   CPU side : merges card read data (q), CRU input (cruin) and READY (ready),
//              counts multi-card drive conflicts, READY watchdog.
//   WB side  : slot decode + single-outstanding forwarding (peb_bus_wb_router).
//   Status   : conflict_count (saturating), wb_timeout_flag, ready_forced;
//              all three cleared by status_clear.
// Cards take wb_adr_i[7:22], wb_dat_i and wb_we_i directly off the shared bus.
module peb_bus
    import peb_pkg::*;
#(
    parameter int SLOTS         = 4,
    parameter int WB_TIMEOUT    = 255,
    parameter int READY_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_clk_en,
    input  logic               memen,
    input  logic               dbin,
    input  logic [8*SLOTS-1:0] slot_q,
    input  logic [SLOTS-1:0]   slot_q_select,
    input  logic [SLOTS-1:0]   slot_cruin,
    input  logic [SLOTS-1:0]   slot_cru_select,
    input  logic [SLOTS-1:0]   slot_ready,
    output logic [7:0]         q,
    output logic               cruin,
    output logic               ready,
    input  logic [0:22]        wb_adr_i,
    input  logic [7:0]         wb_dat_i,
    output logic [7:0]         wb_dat_o,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o,
    output logic [SLOTS-1:0]   slot_wb_stb,
    input  logic [8*SLOTS-1:0] slot_wb_dat,
    input  logic [SLOTS-1:0]   slot_wb_ack,
    output logic [7:0]         conflict_count,
    output logic               wb_timeout_flag,
    output logic               ready_forced,
    input  logic               status_clear
);

    localparam int RW = (READY_TIMEOUT > 0) ? $clog2(READY_TIMEOUT + 1) : 1;

    logic          all_ready;
    logic          force_active;
    logic [RW-1:0] rdy_cnt;
    logic          conflict;
    logic          wd_fire;
    logic          unused_passthru;

    assign unused_passthru = ^{wb_adr_i[7:22], wb_dat_i, wb_we_i};

    always_comb begin
        q     = '0;
        cruin = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (slot_q_select[s])   q     = q | slot_q[8*s +: 8];
            if (slot_cru_select[s]) cruin = cruin | slot_cruin[s];
        end
    end

    assign all_ready = &slot_ready;
    assign ready     = all_ready | force_active;

    assign conflict = (memen && dbin && multi_hot(16'(slot_q_select))) ||
                      multi_hot(16'(slot_cru_select));

    // The tick that takes the counter to READY_TIMEOUT is the one that fires.
    assign wd_fire = cpu_clk_en && !all_ready && (rdy_cnt == RW'(READY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_cnt        <= '0;
            force_active   <= 1'b0;
            ready_forced   <= 1'b0;
            conflict_count <= '0;
        end else begin
            if (all_ready)
                rdy_cnt <= '0;
            else if (cpu_clk_en && rdy_cnt != RW'(READY_TIMEOUT))
                rdy_cnt <= rdy_cnt + 1'b1;

            if (all_ready || !memen) force_active <= 1'b0;
            else if (wd_fire)        force_active <= 1'b1;

            if (wd_fire) ready_forced <= 1'b1;

            if (conflict && conflict_count != 8'hFF)
                conflict_count <= conflict_count + 8'd1;

            if (status_clear) begin
                ready_forced   <= 1'b0;
                conflict_count <= '0;
            end
        end
    end

    peb_bus_wb_router #(
        .SLOTS      (SLOTS),
        .WB_TIMEOUT (WB_TIMEOUT)
    ) u_router (
        .clk             (clk),
        .reset           (reset),
        .status_clear    (status_clear),
        .wb_adr          (wb_adr_i[0:SLOT_LSB+SLOT_W-1]),
        .wb_stb_i        (wb_stb_i),
        .wb_cyc_i        (wb_cyc_i),
        .wb_dat_o        (wb_dat_o),
        .wb_ack_o        (wb_ack_o),
        .slot_wb_stb     (slot_wb_stb),
        .slot_wb_dat     (slot_wb_dat),
        .slot_wb_ack     (slot_wb_ack),
        .wb_timeout_flag (wb_timeout_flag)
    );

endmodule

// File: tb/tb_peb_bus.sv
module tb_peb_bus;

    localparam int SLOTS = 4;
    localparam int WBT   = 255;
    localparam int RDT   = 1023;

    logic               clk = 1'b0;
    logic               reset;
    logic               cpu_clk_en;
    logic               memen, dbin;
    logic [8*SLOTS-1:0] slot_q;
    logic [SLOTS-1:0]   slot_q_select, slot_cruin, slot_cru_select, slot_ready;
    logic [7:0]         q;
    logic               cruin, ready;
    logic [0:22]        wb_adr_i;
    logic [7:0]         wb_dat_i, wb_dat_o;
    logic               wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
    logic [SLOTS-1:0]   slot_wb_stb, slot_wb_ack;
    logic [8*SLOTS-1:0] slot_wb_dat;
    logic [7:0]         conflict_count;
    logic               wb_timeout_flag, ready_forced, status_clear;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    peb_bus #(.SLOTS(SLOTS), .WB_TIMEOUT(WBT), .READY_TIMEOUT(RDT)) dut (
        .clk(clk), .reset(reset), .cpu_clk_en(cpu_clk_en), .memen(memen), .dbin(dbin),
        .slot_q(slot_q), .slot_q_select(slot_q_select), .slot_cruin(slot_cruin),
        .slot_cru_select(slot_cru_select), .slot_ready(slot_ready),
        .q(q), .cruin(cruin), .ready(ready),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .slot_wb_stb(slot_wb_stb), .slot_wb_dat(slot_wb_dat), .slot_wb_ack(slot_wb_ack),
        .conflict_count(conflict_count), .wb_timeout_flag(wb_timeout_flag),
        .ready_forced(ready_forced), .status_clear(status_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One Wishbone read. The card on the strobed slot acks lat_card clk after
    // it first sees its strobe (never if lat_card < 0); every other slot acks
    // continuously to show that stray acks are ignored. lat = clk from stb to
    // ack seen (-1 if none within the bound).
    task automatic wb_txn(input logic [0:22] adr, input int lat_card, input logic [7:0] card_dat,
                          output int lat, output logic [7:0] dat, output logic [SLOTS-1:0] stb_seen);
        int first;
        first    = -1;
        lat      = -1;
        dat      = '0;
        stb_seen = '0;
        @(negedge clk);
        wb_adr_i    = adr;
        wb_cyc_i    = 1'b1;
        wb_stb_i    = 1'b1;
        slot_wb_dat = {SLOTS{8'h5A}};
        slot_wb_ack = '0;
        for (int i = 1; i <= 400 && lat < 0; i++) begin
            @(negedge clk);
            stb_seen = stb_seen | slot_wb_stb;
            if (first < 0 && slot_wb_stb != '0) first = i;
            if (wb_ack_o) begin
                lat = i;
                dat = wb_dat_o;
            end else if (first >= 0) begin
                slot_wb_ack = ~slot_wb_stb;
                if (lat_card >= 0 && i >= first + lat_card) begin
                    slot_wb_ack = slot_wb_stb;
                    for (int s = 0; s < SLOTS; s++)
                        if (slot_wb_stb[s]) slot_wb_dat[8*s +: 8] = card_dat;
                end
            end
        end
        wb_cyc_i    = 1'b0;
        wb_stb_i    = 1'b0;
        slot_wb_ack = '0;
        @(negedge clk);
        chk("ack_one_clk", {31'd0, wb_ack_o}, 32'd0);
    endtask

    int               lat;
    logic [7:0]       dat;
    logic [SLOTS-1:0] stbs;
    logic             ack_any;

    initial begin
        reset = 1'b1; cpu_clk_en = 1'b0; memen = 1'b0; dbin = 1'b0;
        slot_q = '0; slot_q_select = '0; slot_cruin = '0; slot_cru_select = '0;
        slot_ready = '1; wb_adr_i = '0; wb_dat_i = 8'h00; wb_we_i = 1'b0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; slot_wb_dat = '0; slot_wb_ack = '0;
        status_clear = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_q",        {24'd0, q},              32'h00);
        chk("rst_ready",    {31'd0, ready},          32'd1);
        chk("rst_conflict", {24'd0, conflict_count}, 32'd0);
        chk("rst_flags",    {30'd0, wb_timeout_flag, ready_forced}, 32'd0);
        chk("rst_wb",       {23'd0, wb_ack_o, wb_dat_o}, 32'd0);
        chk("rst_stb",      {28'd0, slot_wb_stb},    32'd0);

        // read merge: only slot 1 selected
        memen = 1'b1; dbin = 1'b1;
        slot_q = 32'h7766A533; slot_q_select = 4'b0010;
        #1 chk("q_slot1", {24'd0, q}, 32'hA5);
        @(negedge clk);
        chk("q_no_conflict", {24'd0, conflict_count}, 32'd0);

        // CRU merge
        slot_cru_select = 4'b0100; slot_cruin = 4'b0100;
        #1 chk("cru_sel_hi", {31'd0, cruin}, 32'd1);
        slot_cruin = 4'b1011;
        #1 chk("cru_sel_lo", {31'd0, cruin}, 32'd0);
        slot_cru_select = '0;

        // read conflict for 3 clk
        @(negedge clk);
        slot_q_select = 4'b0101;
        #1 chk("q_or_merge", {24'd0, q}, 32'h77);
        repeat (3) @(negedge clk);
        slot_q_select = 4'b0010;
        chk("conflict_3", {24'd0, conflict_count}, 32'd3);

        // multi-select without a read cycle is not a conflict
        memen = 1'b0; slot_q_select = 4'b0101;
        repeat (2) @(negedge clk);
        chk("no_read_no_conflict", {24'd0, conflict_count}, 32'd3);
        // CRU conflict counts regardless of memen
        slot_q_select = '0; slot_cru_select = 4'b0011;
        repeat (2) @(negedge clk);
        chk("cru_conflict", {24'd0, conflict_count}, 32'd5);
        slot_cru_select = '0;

        // saturation, then clear while the conflict persists
        memen = 1'b1; slot_q_select = 4'b0101;
        repeat (300) @(negedge clk);
        chk("conflict_sat", {24'd0, conflict_count}, 32'hFF);
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0; slot_q_select = '0;
        chk("conflict_clear", {24'd0, conflict_count}, 32'd0);

        // WB read slot 2, card acks 4 clk after strobe
        wb_txn({3'b000, 4'd2, 16'h1234}, 4, 8'h3C, lat, dat, stbs);
        chk("wb2_lat",  lat,             32'd6);
        chk("wb2_dat",  {24'd0, dat},    32'h3C);
        chk("wb2_stb",  {28'd0, stbs},   32'b0100);

        // highest valid slot, card acks immediately
        wb_txn({3'b000, 4'd3, 16'h0000}, 0, 8'hC3, lat, dat, stbs);
        chk("wb3_lat",  lat,           32'd2);
        chk("wb3_dat",  {24'd0, dat},  32'hC3);
        chk("wb3_stb",  {28'd0, stbs}, 32'b1000);

        // slot beyond SLOTS
        wb_txn({3'b000, 4'd7, 16'h0000}, 0, 8'h11, lat, dat, stbs);
        chk("wb7_lat",  lat,           32'd1);
        chk("wb7_dat",  {24'd0, dat},  32'hFF);
        chk("wb7_stb",  {28'd0, stbs}, 32'd0);

        // nonzero region bits
        wb_txn({3'b001, 4'd1, 16'h0000}, 0, 8'h11, lat, dat, stbs);
        chk("wbreg_lat", lat,           32'd1);
        chk("wbreg_dat", {24'd0, dat},  32'hFF);
        chk("wb_no_tmo_yet", {31'd0, wb_timeout_flag}, 32'd0);

        // slot 0 never acks
        wb_txn({3'b000, 4'd0, 16'h0000}, -1, 8'h00, lat, dat, stbs);
        chk("tmo_lat",  lat,          WBT + 2);
        chk("tmo_dat",  {24'd0, dat}, 32'hFF);
        chk("tmo_flag", {31'd0, wb_timeout_flag}, 32'd1);
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
        chk("tmo_flag_clr", {31'd0, wb_timeout_flag}, 32'd0);

        // master drops cyc mid-BUSY
        wb_adr_i = {3'b000, 4'd0, 16'h0000}; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_stb_busy", {28'd0, slot_wb_stb}, 32'b0001);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        ack_any = 1'b0;
        repeat (6) begin
            @(negedge clk);
            ack_any = ack_any | wb_ack_o;
        end
        chk("abort_no_ack", {31'd0, ack_any}, 32'd0);
        chk("abort_stb_off", {28'd0, slot_wb_stb}, 32'd0);
        wb_txn({3'b000, 4'd9, 16'h0000}, 0, 8'h00, lat, dat, stbs);
        chk("abort_idle", lat, 32'd1);

        // reset in the middle of a transaction
        wb_adr_i = {3'b000, 4'd1, 16'h0000}; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_busy", {28'd0, slot_wb_stb}, 32'b0010);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_stb", {28'd0, slot_wb_stb}, 32'd0);
        chk("rstmid_ack", {31'd0, wb_ack_o},   32'd0);
        reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        chk("rstmid_ack2", {31'd0, wb_ack_o}, 32'd0);

        // READY watchdog: slot 3 stuck, tick every 3rd clk
        memen = 1'b1; slot_ready = 4'b0111;
        #1 chk("wd_ready_low", {31'd0, ready}, 32'd0);
        for (int t = 1; t <= RDT; t++) begin
            @(negedge clk); cpu_clk_en = 1'b1;
            @(negedge clk); cpu_clk_en = 1'b0;
            if (t == RDT - 1) begin
                chk("wd_before_ready", {31'd0, ready},        32'd0);
                chk("wd_before_flag",  {31'd0, ready_forced}, 32'd0);
            end
            @(negedge clk);
        end
        chk("wd_ready_forced", {31'd0, ready},        32'd1);
        chk("wd_flag",         {31'd0, ready_forced}, 32'd1);
        slot_ready = '1;
        @(negedge clk);
        slot_ready = 4'b0111;
        #1 chk("wd_force_ends", {31'd0, ready},        32'd0);
        chk("wd_flag_sticky",   {31'd0, ready_forced}, 32'd1);
        @(negedge clk);
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
        chk("wd_flag_clr", {31'd0, ready_forced}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
